// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, default width and the serial ALU state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SLTFIX = 2'd2,
    DONE   = 2'd3
  } serial_alu_state_t;

  // Ops that route the adder leg and advance the carry chain.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALUOP_ADD) || (op == ALUOP_SUB) || (op == ALUOP_SLT);
  endfunction

  // Ops whose carry-out and overflow are reported on the flags.
  function automatic logic reports_carry(input logic [2:0] op);
    return (op == ALUOP_ADD) || (op == ALUOP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU cell: optional B inversion, AND/OR legs and a full adder.
module serial_alu_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic invert,
  input  logic carry_in,
  output logic and_o,
  output logic or_o,
  output logic sum_o,
  output logic carry_o
);

  logic w_b;

  assign w_b     = b_i ^ invert;
  assign and_o   = a_i & w_b;
  assign or_o    = a_i | w_b;
  assign sum_o   = a_i ^ w_b ^ carry_in;
  assign carry_o = (a_i & w_b) | (a_i & carry_in) | (w_b & carry_in);

endmodule

// File: rtl/alu32_serial.sv
// Bit-serial ALU: one bit per clock, LSB first, through a single slice with a registered carry.
module alu32_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  serial_alu_state_t r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [2:0]        r_op;
  logic              r_carry;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_int;
  logic [WIDTH-1:0]  r_result;
  logic              r_busy;
  logic              r_done;
  logic              r_zero;
  logic              r_cout;
  logic              r_overflow;

  logic             w_and;
  logic             w_or;
  logic             w_sum;
  logic             w_carry;
  logic             w_bit;
  logic [WIDTH-1:0] w_res_shift;
  logic             w_slt_bit;

  serial_alu_slice u_slice (
    .a_i      (r_a[0]),
    .b_i      (r_b[0]),
    .invert   (r_op[2]),
    .carry_in (r_carry),
    .and_o    (w_and),
    .or_o     (w_or),
    .sum_o    (w_sum),
    .carry_o  (w_carry)
  );

  // Leg select; unknown opcodes shift in zeros so the result ends up 0.
  always_comb begin
    w_bit = 1'b0;
    case (r_op)
      ALUOP_AND: w_bit = w_and;
      ALUOP_OR:  w_bit = w_or;
      ALUOP_ADD,
      ALUOP_SUB,
      ALUOP_SLT: w_bit = w_sum;
      default:   w_bit = 1'b0;
    endcase
  end

  assign w_res_shift = {w_bit, r_result[WIDTH-1:1]};
  // After RUN the MSB of the result holds the sign of a-b for SLT.
  assign w_slt_bit   = r_result[WIDTH-1] ^ r_ovf_int;

  // Sequencer, datapath registers and flag capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 3'b000;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_ovf_int  <= 1'b0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_zero     <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= aluop;
            r_carry <= aluop[2];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_result <= w_res_shift;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (is_arith(r_op)) begin
            r_carry <= w_carry;
          end
          if (r_cnt == CNT_LAST) begin
            r_ovf_int <= r_carry ^ w_carry;
            if (r_op == ALUOP_SLT) begin
              r_state <= SLTFIX;
            end else begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_zero     <= (w_res_shift == '0);
              r_cout     <= reports_carry(r_op) & w_carry;
              r_overflow <= reports_carry(r_op) & (r_carry ^ w_carry);
            end
          end
        end
        SLTFIX: begin
          r_result   <= {{(WIDTH-1){1'b0}}, w_slt_bit};
          r_zero     <= ~w_slt_bit;
          r_cout     <= 1'b0;
          r_overflow <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign zero     = r_zero;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule
